// File: rtl/regctl_pkg.sv
// regctl_pkg: shared state encoding, register count and transfer-direction constants.
package regctl_pkg;
  localparam int NUM_REGS = 8;
  localparam logic MODE_SAVE = 1'b0;
  localparam logic MODE_RESTORE = 1'b1;
  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;
endpackage

// File: rtl/regfile_context_ctrl_if.sv
// regfile_context_ctrl_if: request, register-file and memory signals of the context controller.
interface regfile_context_ctrl_if;
  import regctl_pkg::*;
  logic start;
  logic mode;
  logic [NUM_REGS-1:0] mask;
  logic [15:0] base_addr;
  logic [2:0] sr1_sel;
  logic [15:0] sr1_data;
  logic [2:0] dr_sel;
  logic ld_reg;
  logic [15:0] reg_wr_data;
  logic mem_req;
  logic mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic mem_ack;
  logic busy;
  logic done;
  modport master (
    input start, mode, mask, base_addr, sr1_data, mem_rdata, mem_ack,
    output sr1_sel, dr_sel, ld_reg, reg_wr_data, mem_req, mem_we, mem_addr, mem_wdata, busy, done
  );
  modport slave (
    output start, mode, mask, base_addr, sr1_data, mem_rdata, mem_ack,
    input sr1_sel, dr_sel, ld_reg, reg_wr_data, mem_req, mem_we, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/find_next_reg.sv
// find_next_reg: lowest set mask bit at or above start_idx.
module find_next_reg
  import regctl_pkg::*;
(
  input  logic [NUM_REGS-1:0] mask,
  input  logic [3:0]          start_idx,
  output logic [2:0]          index,
  output logic                valid
);
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = NUM_REGS - 1; i >= 0; i--)
      if (mask[i] && 4'(i) >= start_idx) begin
        index = 3'(i);
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/regfile_context_ctrl.sv
// regfile_context_ctrl: saves/restores a masked set of registers to/from consecutive memory words.
module regfile_context_ctrl
  import regctl_pkg::*;
(
  input logic clk,
  input logic rst_n,
  regfile_context_ctrl_if.master bus
);
  state_t state;
  logic mode_q;
  logic [NUM_REGS-1:0] mask_q;
  logic [15:0] base_q, cnt;
  logic [2:0] cur, nxt;
  logic nxt_ok, adv, launch, l_save;
  logic [15:0] l_addr;
  find_next_reg u_find (
    .mask(state == IDLE ? bus.mask : mask_q),
    .start_idx(state == IDLE ? 4'd0 : {1'b0, cur} + 4'd1),
    .index(nxt),
    .valid(nxt_ok)
  );
  // Both the initial start and every completed word fall into one "issue next transfer" path.
  assign adv = state == WB || (state == XFER && bus.mem_ack && mode_q == MODE_SAVE);
  assign launch = (state == IDLE && bus.start) || adv;
  assign l_save = (state == IDLE ? bus.mode : mode_q) == MODE_SAVE;
  assign l_addr = state == IDLE ? bus.base_addr : base_q + cnt + 16'd1;
  assign bus.mem_wdata = bus.mem_req && bus.mem_we ? bus.sr1_data : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mode_q <= MODE_SAVE;
      mask_q <= '0;
      base_q <= '0;
      cnt <= '0;
      cur <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.sr1_sel <= '0;
      bus.dr_sel <= '0;
      bus.ld_reg <= 1'b0;
      bus.reg_wr_data <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          mode_q <= bus.mode;
          mask_q <= bus.mask;
          base_q <= bus.base_addr;
          bus.busy <= 1'b1;
        end
        XFER: if (bus.mem_ack && mode_q == MODE_RESTORE) begin
          state <= WB;
          bus.mem_req <= 1'b0;
          bus.mem_addr <= '0;
          bus.ld_reg <= 1'b1;
          bus.dr_sel <= cur;
          bus.reg_wr_data <= bus.mem_rdata;
        end
        WB: begin
          bus.ld_reg <= 1'b0;
          bus.dr_sel <= '0;
          bus.reg_wr_data <= '0;
        end
        DONE: begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (launch) begin
        cnt <= state == IDLE ? '0 : cnt + 16'd1;
        cur <= nxt;
        state <= nxt_ok ? XFER : DONE;
        bus.done <= !nxt_ok;
        bus.mem_req <= nxt_ok;
        bus.mem_we <= nxt_ok && l_save;
        bus.mem_addr <= nxt_ok ? l_addr : '0;
        bus.sr1_sel <= nxt_ok && l_save ? nxt : '0;
      end
    end
endmodule

// File: tb/tb_regfile_context_ctrl.sv
// tb_regfile_context_ctrl: randomized bench comparing the controller against a per-cycle expected-step script.
module tb_regfile_context_ctrl;
  import regctl_pkg::*;
  typedef enum {S_X, S_W, S_D} kind_t;
  typedef struct {
    kind_t kind;
    logic we;
    logic [2:0] r;
    logic [15:0] addr;
    logic [15:0] data;
    int wt;
  } step_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [15:0] regs [8];
  logic [15:0] mem [65536];
  step_t q[$];
  int checks = 0, errors = 0, wcnt = 0, wait_mode = 0, wr_cnt = 0;
  regfile_context_ctrl_if bus();
  regfile_context_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.sr1_data = regs[bus.sr1_sel];
  // environment: memory and register file react to the DUT's strobes
  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_we && bus.mem_ack) begin
      mem[bus.mem_addr] = bus.mem_wdata;
      wr_cnt++;
    end
    if (bus.ld_reg) regs[bus.dr_sel] = bus.reg_wr_data;
  end
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  // Expected script: one X step per selected register (ascending index, consecutive addresses),
  // a W step after each X when restoring, and a final D step.
  task automatic start_op(input logic m, input logic [7:0] mk, input logic [15:0] b);
    int k = 0;
    step_t s;
    bus.start = 1'b1;
    bus.mode = m;
    bus.mask = mk;
    bus.base_addr = b;
    for (int i = 0; i < 8; i++)
      if (mk[i]) begin
        s.kind = S_X;
        s.we = m == MODE_SAVE;
        s.r = 3'(i);
        s.addr = b + 16'(k);
        s.data = m == MODE_SAVE ? regs[i] : mem[s.addr];
        s.wt = wait_mode < 0 ? int'($urandom_range(0, 3)) : wait_mode;
        q.push_back(s);
        if (m == MODE_RESTORE) begin
          s.kind = S_W;
          q.push_back(s);
        end
        k++;
      end
    s = '{S_D, 1'b0, 3'd0, 16'd0, 16'd0, 0};
    q.push_back(s);
  endtask
  always @(negedge clk) begin
    chk("busy", 16'(bus.busy), 16'(q.size() != 0));
    if (q.size() == 0 || q[0].kind != S_X) begin
      chk("req_off", 16'(bus.mem_req), 16'd0);
      bus.mem_ack = 1'($urandom);
      bus.mem_rdata = 16'($urandom);
    end
    if (q.size() == 0) begin
      chk("idle_ld", 16'(bus.ld_reg), 16'd0);
      chk("idle_done", 16'(bus.done), 16'd0);
    end else if (q[0].kind == S_X) begin
      chk("x_req", 16'(bus.mem_req), 16'd1);
      chk("x_we", 16'(bus.mem_we), 16'(q[0].we));
      chk("x_addr", bus.mem_addr, q[0].addr);
      chk("x_ld", 16'(bus.ld_reg), 16'd0);
      chk("x_done", 16'(bus.done), 16'd0);
      if (q[0].we) begin
        chk("x_sel", 16'(bus.sr1_sel), 16'(q[0].r));
        chk("x_wdata", bus.mem_wdata, q[0].data);
      end
      bus.mem_ack = wcnt >= q[0].wt;
      bus.mem_rdata = bus.mem_ack ? mem[q[0].addr] : 16'($urandom);
      if (bus.mem_ack) begin
        void'(q.pop_front());
        wcnt = 0;
      end else wcnt++;
    end else if (q[0].kind == S_W) begin
      chk("wb_ld", 16'(bus.ld_reg), 16'd1);
      chk("wb_sel", 16'(bus.dr_sel), 16'(q[0].r));
      chk("wb_data", bus.reg_wr_data, q[0].data);
      chk("wb_done", 16'(bus.done), 16'd0);
      void'(q.pop_front());
    end else begin
      chk("d_done", 16'(bus.done), 16'd1);
      chk("d_ld", 16'(bus.ld_reg), 16'd0);
      void'(q.pop_front());
    end
  end
  task automatic run_op(input logic m, input logic [7:0] mk, input logic [15:0] b, input int wm,
                        input bit noise, output int n, output int lds, output int reqs);
    wait_mode = wm;
    @(negedge clk);
    #1;
    start_op(m, mk, b);
    n = 0;
    lds = 0;
    reqs = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      lds += int'(bus.ld_reg);
      reqs += int'(bus.mem_req);
      bus.start = noise && $urandom_range(0, 2) == 0;
      bus.mode = 1'($urandom);
      bus.mask = 8'($urandom);
      bus.base_addr = 16'($urandom);
    end while (!bus.done && n < 200);
    bus.start = 1'b0;
    chk("done_seen", 16'(bus.done), 16'd1);
  endtask
  initial begin
    int n, l, r, w0;
    logic [15:0] saved4, old5;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.mask = '0;
    bus.base_addr = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_done", 16'(bus.done), 16'd0);
    chk("rst_req", 16'(bus.mem_req), 16'd0);
    chk("rst_we", 16'(bus.mem_we), 16'd0);
    chk("rst_ld", 16'(bus.ld_reg), 16'd0);
    chk("rst_addr", bus.mem_addr, 16'd0);
    chk("rst_wdata", bus.mem_wdata, 16'd0);
    chk("rst_wrdata", bus.reg_wr_data, 16'd0);
    chk("rst_sels", {10'd0, bus.sr1_sel, bus.dr_sel}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    regs[0] = 16'hA0A0;
    regs[7] = 16'h7777;
    run_op(MODE_SAVE, 8'h81, 16'h3000, 0, 1'b0, n, l, r);
    chk("save81_cycles", 16'(n), 16'd3);
    chk("save81_m3000", mem[16'h3000], 16'hA0A0);
    chk("save81_m3001", mem[16'h3001], 16'h7777);
    mem[16'h4000] = 16'hBEEF;
    mem[16'h4001] = 16'h1234;
    run_op(MODE_RESTORE, 8'h06, 16'h4000, 0, 1'b1, n, l, r);
    chk("rest06_cycles", 16'(n), 16'd5);
    chk("rest06_r1", regs[1], 16'hBEEF);
    chk("rest06_r2", regs[2], 16'h1234);
    chk("rest06_ld_cycles", 16'(l), 16'd2);
    w0 = wr_cnt;
    run_op(MODE_SAVE, 8'h2C, 16'h5000, 3, 1'b0, n, l, r);
    chk("slow_cycles", 16'(n), 16'd13);
    chk("slow_writes", 16'(wr_cnt - w0), 16'd3);
    chk("slow_m5000", mem[16'h5000], regs[2]);
    chk("slow_m5002", mem[16'h5002], regs[5]);
    run_op(MODE_SAVE, 8'h00, 16'h1234, 0, 1'b0, n, l, r);
    chk("zero_cycles", 16'(n), 16'd1);
    chk("zero_reqs", 16'(r), 16'd0);
    run_op(MODE_SAVE, 8'h03, 16'hFFFF, 1, 1'b0, n, l, r);
    chk("wrap_mffff", mem[16'hFFFF], regs[0]);
    chk("wrap_m0000", mem[16'h0000], regs[1]);
    for (int t = 0; t < 40; t++)
      run_op(1'($urandom), $urandom_range(0, 5) == 0 ? 8'h00 : 8'($urandom),
             $urandom_range(0, 3) == 0 ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom),
             -1, 1'b1, n, l, r);
    wait_mode = -1;
    old5 = regs[5];
    saved4 = mem[16'h6000];
    @(negedge clk);
    #1;
    start_op(MODE_RESTORE, 8'h30, 16'h6000);
    n = 0;
    l = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      l += int'(bus.ld_reg);
      bus.start = 1'b1;
      bus.mode = MODE_SAVE;
      bus.mask = 8'hFF;
    end while (l < 2 && n < 100);
    chk("rst_mid_reached", 16'(l), 16'd2);
    bus.start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ld", 16'(bus.ld_reg), 16'd0);
    chk("rst_mid_busy", 16'(bus.busy), 16'd0);
    q.delete();
    wcnt = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    chk("rst_mid_r4_kept", regs[4], saved4);
    chk("rst_mid_r5_untouched", regs[5], old5);
    run_op(MODE_SAVE, 8'h10, 16'h7000, 0, 1'b0, n, l, r);
    chk("after_rst_m7000", mem[16'h7000], regs[4]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_context_ctrl.md
REGFILE_CONTEXT_CTRL -- requirements
Module: regfile_context_ctrl

Interface
REQ-001 SHALL have ports: Clk in 1, single clock; all state changes on rising edge.
REQ-002 SHALL have ports: Reset in 1, asynchronous, active-low; clears all state immediately when low.
REQ-003 SHALL have ports: Start in 1, request pulse; sampled only in IDLE.
REQ-004 SHALL have ports: Mode in 1, 0 = save (regs to memory), 1 = restore (memory to regs).
REQ-005 SHALL have ports: Mask in 8, bit i selects Ri for transfer.
REQ-006 SHALL have ports: Base_Addr in 16, first memory word address.
REQ-007 SHALL have ports: SR1_Sel out 3, register-file read select; SR1_Data in 16, register-file read data.
REQ-008 SHALL have ports: DR_Sel out 3, LD_REG out 1, Reg_Wr_Data out 16, register-file write port (Reg_Wr_Data drives BUS_val).
REQ-009 SHALL have ports: Mem_Req out 1, Mem_WE out 1, Mem_Addr out 16, Mem_Wdata out 16, Mem_Rdata in 16, Mem_Ack in 1.
REQ-010 SHALL have ports: Busy out 1, high when not IDLE; Done out 1, one-cycle completion pulse.

Function
REQ-011 SHALL implement states IDLE, XFER, WB, DONE.
REQ-012 SHALL, in IDLE with Start=1, latch Mode, Mask and Base_Addr, clear word counter, and go to XFER if Mask != 0, else DONE.
REQ-013 SHALL select the current register as the lowest set Mask bit at index >= current pointer; the next register is the lowest set bit above it.
REQ-014 SHALL, in XFER, hold Mem_Req=1 with Mem_Addr = Base + counter (mod 2^16, wraps FFFF->0000).
REQ-015 SHALL, in save XFER, drive Mem_WE=1, SR1_Sel = current reg and Mem_Wdata = SR1_Data.
REQ-016 SHALL, in restore XFER, drive Mem_WE=0 and capture Mem_Rdata into an internal 16-bit register on the Mem_Ack cycle.
REQ-017 SHALL treat Req&&Ack on the same edge as the transfer; address/data/WE stay stable until Ack; no timeout.
REQ-018 SHALL, on save Ack, increment the counter and go to XFER for the next reg, or to DONE if none remains.
REQ-019 SHALL, on restore Ack, go to WB; WB lasts 1 cycle with LD_REG=1, DR_Sel = current reg and Reg_Wr_Data = captured word, then goes to XFER/DONE by the REQ-018 rule.
REQ-020 SHALL hold LD_REG=0 in all states except WB, and Mem_Req=0 outside XFER.
REQ-021 SHALL assert Done=1 for exactly the single DONE cycle, then return to IDLE.
REQ-022 SHALL ignore Start while Busy=1; Mask/Mode/Base changes mid-operation SHALL have no effect.
REQ-023 SHALL give these latencies with zero-wait Ack: save of N regs = N XFER cycles + 1 DONE cycle; restore = 2N + 1 cycles.
REQ-024 SHALL, on Start with Mask=0, spend 1 cycle in DONE (Done pulse) and issue no memory or register access.

Reset
REQ-025 SHALL, on Reset low, go to IDLE and drive Busy, Done, Mem_Req, Mem_WE, LD_REG = 0 and all buses/selects = 0.
REQ-026 SHALL, when Reset asserts mid-operation, abandon the transfer with no further LD_REG; earlier completed writes remain.

Structure
REQ-027 SHALL put the state enum, NUM_REGS=8 and MODE_SAVE/MODE_RESTORE constants in shared package regctl_pkg.
REQ-028 SHALL implement the next-set-bit search as sub-module find_next_reg (Mask, start index in; index, valid out; combinational).

Verification
REQ-029 SHALL cover: save, Mask=8'h81, Base=x3000, Ack tied high -> writes R0 to x3000 and R7 to x3001, Done in cycle 3 after Start.
REQ-030 SHALL cover: restore, Mask=8'h06, Base=x4000, memory x4000=xBEEF, x4001=x1234 -> R1=xBEEF, R2=x1234, LD_REG high for exactly 2 cycles.
REQ-031 SHALL cover: save with Ack delayed 3 cycles per word -> Mem_Addr/Mem_Wdata stable while Req high; exactly one write per reg.
REQ-032 SHALL cover: Start with Mask=0 -> Done one cycle after Start, Mem_Req never high.
REQ-033 SHALL cover: Base=xFFFF, Mask=8'h03, save -> addresses xFFFF then x0000.
REQ-034 SHALL cover: Reset low during restore WB wait -> LD_REG=0 and Busy=0 immediately; a second Start while Busy is ignored.
